// File: rtl/board_tile_writer.sv
// Write side of the board row RAM: copies the init ROM in on level start, then
// serves single-tile set/clear requests by read-modify-write and tracks set tiles.
module board_tile_writer #(
    parameter int ROWS = 21,
    parameter int COLS = 21,
    parameter int AW   = 5,
    parameter int CW   = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_load,
    output logic [AW-1:0]   rom_addr,
    input  logic [COLS-1:0] rom_data,
    output logic [AW-1:0]   ram_addr,
    input  logic [COLS-1:0] ram_rdata,
    output logic [COLS-1:0] ram_wdata,
    output logic            ram_we,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_x,
    input  logic [AW-1:0]   req_y,
    input  logic            req_set,
    output logic            resp_valid,
    output logic            resp_hit,
    output logic            load_done,
    output logic            busy,
    output logic [CW-1:0]   tile_count,
    output logic            board_empty
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [AW:0] ROWS_L = (AW+1)'(ROWS);
    localparam logic [AW:0] COLS_L = (AW+1)'(COLS);
    localparam logic [CW:0] MAXT_L = (CW+1)'(ROWS * COLS);

    logic [2:0]    state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] x_q, x_d, y_q, y_d;
    logic          set_q, set_d, hit_q, hit_d;
    logic [CW-1:0] tc_q, tc_d;
    logic          loaded_q, loaded_d, done_q, done_d;

    logic            in_range;
    logic [COLS-1:0] mask;
    logic            old_bit;
    logic [CW:0]     load_sum;

    function automatic logic [CW:0] popcount(input logic [COLS-1:0] v);
        logic [CW:0] pc;
        pc = '0;
        for (int i = 0; i < COLS; i++) pc = pc + (CW+1)'(v[i]);
        return pc;
    endfunction

    assign in_range = ({1'b0, x_q} < COLS_L) && ({1'b0, y_q} < ROWS_L);
    assign mask     = COLS'(1) << x_q;
    assign old_bit  = |(ram_rdata & mask);
    assign load_sum = {1'b0, tc_q} + popcount(rom_data);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        set_d     = set_q;
        hit_d     = hit_q;
        tc_d      = tc_q;
        loaded_d  = loaded_q;
        done_d    = 1'b0;
        rom_addr  = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = ~start_load;
                if (start_load) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    tc_d    = '0;
                end else if (req_valid) begin
                    x_d      = req_x;
                    y_d      = req_y;
                    set_d    = req_set;
                    ram_addr = req_y;
                    state_d  = S_RD;
                end
            end
            S_LOAD: begin
                // ROM is one cycle behind, so cycle k reads row k and writes row k-1
                if (cnt_q < ROWS_L) rom_addr = AW'(cnt_q);
                if (cnt_q != '0) begin
                    ram_we    = 1'b1;
                    ram_addr  = AW'(cnt_q - (AW+1)'(1));
                    ram_wdata = rom_data;
                    tc_d      = (load_sum > MAXT_L) ? MAXT_L[CW-1:0] : load_sum[CW-1:0];
                end
                if (cnt_q == ROWS_L) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    loaded_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + (AW+1)'(1);
                end
            end
            S_RD: begin
                ram_addr = y_q;
                state_d  = S_WR;
            end
            S_WR: begin
                ram_addr = y_q;
                hit_d    = 1'b0;
                if (in_range) begin
                    ram_we    = 1'b1;
                    ram_wdata = set_q ? (ram_rdata | mask) : (ram_rdata & ~mask);
                    hit_d     = old_bit;
                    if (set_q && !old_bit && ({1'b0, tc_q} < MAXT_L))
                        tc_d = tc_q + CW'(1);
                    else if (!set_q && old_bit && (tc_q != '0))
                        tc_d = tc_q - CW'(1);
                end
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            set_q    <= 1'b0;
            hit_q    <= 1'b0;
            tc_q     <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            set_q    <= set_d;
            hit_q    <= hit_d;
            tc_q     <= tc_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
        end
    end

    assign resp_valid  = (state_q == S_RESP);
    assign resp_hit    = resp_valid & hit_q;
    assign load_done   = done_q;
    assign busy        = (state_q != S_IDLE);
    assign tile_count  = tc_q;
    assign board_empty = loaded_q && (tc_q == '0);

endmodule

// File: tb/tb_board_tile_writer.sv
// Directed bench for board_tile_writer with ROM/RAM models and a response scoreboard.
module tb_board_tile_writer;
    localparam int ROWS = 21, COLS = 21, AW = 5, CW = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_load;
    logic [AW-1:0]   rom_addr;
    logic [COLS-1:0] rom_data;
    logic [AW-1:0]   ram_addr;
    logic [COLS-1:0] ram_rdata;
    logic [COLS-1:0] ram_wdata;
    logic            ram_we;
    logic            req_valid, req_ready, req_set;
    logic [AW-1:0]   req_x, req_y;
    logic            resp_valid, resp_hit, load_done, busy, board_empty;
    logic [CW-1:0]   tile_count;

    board_tile_writer #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start_load(start_load),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .req_set(req_set), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .load_done(load_done), .busy(busy), .tile_count(tile_count), .board_empty(board_empty)
    );

    always #5 clk = ~clk;

    logic [COLS-1:0] rom [0:31];
    logic [COLS-1:0] mem [0:31];
    logic            poke_en = 1'b0;
    logic [AW-1:0]   poke_addr = '0;
    logic [COLS-1:0] poke_data = '0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom[i] = '0;
            mem[i] = '0;
        end
        rom[0] = 21'h1FFFFF;
    end

    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (poke_en) mem[poke_addr] <= poke_data;
    end

    int cyc = 0, ld_cnt = 0, we_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_done) ld_cnt <= ld_cnt + 1;
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic hit; int due; } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
                chk("resp_latency", cyc, e.due);
            end
        end
    end

    task automatic do_req(input int x, input int y, input logic s, input logic exp, output int waited);
        int t;
        @(negedge clk);
        req_x = AW'(x); req_y = AW'(y); req_set = s; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) chk("req_accept_timeout", 32'd0, 32'd1);
        else sb.push_back('{exp, cyc + 3});
        @(posedge clk);
        #1 req_valid = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_load(output int busy_n);
        @(negedge clk);
        start_load = 1'b1;
        @(posedge clk);
        #1 start_load = 1'b0;
        busy_n = 0;
        @(negedge clk);
        while (busy && busy_n < 100) begin
            busy_n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bn, w, ld0, we0;
        reset = 1'b1; start_load = 1'b0; req_valid = 1'b0;
        req_x = '0; req_y = '0; req_set = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {25'd0, resp_valid, resp_hit, load_done, board_empty, ram_we,
                         |rom_addr, |ram_addr}, 32'd0);
        chk("rst_tile_count", 32'(tile_count), 32'd0);
        reset = 1'b0;

        // initial load
        ld0 = ld_cnt;
        do_load(bn);
        chk("load_busy_cycles", bn, 22);
        chk("load_done_pulse", {31'd0, load_done}, 32'd1);
        @(negedge clk);
        chk("load_done_once", ld_cnt - ld0, 1);
        chk("load_row0", 32'(mem[0]), 32'h1FFFFF);
        chk("load_count", 32'(tile_count), 32'd21);
        chk("load_not_empty", {31'd0, board_empty}, 32'd0);

        // clear hit, clear miss, out of range, set at far corner, set back
        do_req(3, 0, 1'b0, 1'b1, w);
        chk("clr_hit_row0", 32'(mem[0]), 32'h1FFFF7);
        chk("clr_hit_count", 32'(tile_count), 32'd20);
        do_req(3, 0, 1'b0, 1'b0, w);
        chk("clr_miss_row0", 32'(mem[0]), 32'h1FFFF7);
        chk("clr_miss_count", 32'(tile_count), 32'd20);
        we0 = we_cnt;
        do_req(21, 0, 1'b1, 1'b0, w);
        do_req(0, 21, 1'b0, 1'b0, w);
        chk("oor_no_we", we_cnt - we0, 0);
        chk("oor_count", 32'(tile_count), 32'd20);
        do_req(20, 20, 1'b1, 1'b0, w);
        chk("set_corner_row", 32'(mem[20]), 32'h100000);
        chk("set_corner_count", 32'(tile_count), 32'd21);
        do_req(3, 0, 1'b1, 1'b0, w);
        chk("set_back_row0", 32'(mem[0]), 32'h1FFFFF);
        chk("set_back_count", 32'(tile_count), 32'd22);

        // start_load wins over a same-cycle request
        @(negedge clk);
        start_load = 1'b1; req_valid = 1'b1; req_x = 5'd3; req_y = 5'd0; req_set = 1'b0;
        #1 chk("prio_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 start_load = 1'b0;
        do_req(3, 0, 1'b0, 1'b1, w);
        chk("prio_wait_cycles", w, 22);
        chk("prio_row20_reloaded", 32'(mem[20]), 32'd0);
        chk("prio_count", 32'(tile_count), 32'd20);

        // reset in LOAD cycle 10
        @(negedge clk);
        start_load = 1'b1;
        @(posedge clk);
        #1 start_load = 1'b0;
        repeat (11) @(negedge clk);
        chk("midload_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_we", {31'd0, ram_we}, 32'd0);
        chk("midrst_count", 32'(tile_count), 32'd0);
        chk("midrst_empty", {31'd0, board_empty}, 32'd0);

        rom[7] = 21'h00000F;
        do_load(bn);
        chk("reload_busy_cycles", bn, 22);
        chk("reload_row7", 32'(mem[7]), 32'hF);
        chk("reload_count", 32'(tile_count), 32'd25);

        // empty board, then clearing a stray bit saturates at zero
        rom[0] = '0; rom[7] = '0;
        do_load(bn);
        @(negedge clk);
        chk("empty_count", 32'(tile_count), 32'd0);
        chk("empty_flag", {31'd0, board_empty}, 32'd1);
        poke_addr = 5'd2; poke_data = 21'h1; poke_en = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
        do_req(0, 2, 1'b0, 1'b1, w);
        chk("sat0_row2", 32'(mem[2]), 32'd0);
        chk("sat0_count", 32'(tile_count), 32'd0);
        chk("sat0_empty", {31'd0, board_empty}, 32'd1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
